snake_game_ctrl: RTL
====================

// Module: snake_game_ctrl
// PURPOSE
//  Game-flow controller for the VGA snake game. Sequences IDLE/PLAY/GROW/RESPAWN/OVER and
//  turns the slow update strobe into a single body-shift pulse.
//  Filters PS/2 direction codes so the head never reverses; owns snake length and score.
//  Runs the apple-respawn handshake with the random-position logic.
//  Sits between modul_PS2/update_clk and the snake body registers and collision logic.
// PARAMETERS
//  MAX_SIZE   16  max snake length in segments; size saturates here
//  INIT_SIZE  1   length after reset/IDLE (1 <= INIT_SIZE <= MAX_SIZE)
//  SIZE_W     7   width of size output (must hold MAX_SIZE)
//  SCORE_W    8   width of score counter
// PORTS
//  clk            in   1        system clock; all logic on rising edge
//  rst            in   1        synchronous reset, active-high
//  start          in   1        game-enable switch, level; low forces IDLE
//  tick           in   1        update strobe; a single-cycle pulse, synchronous to clk
//  dir_in         in   5        one-hot direction: 00010 up, 00100 left, 01000 down, 10000 right
//  dir_valid      in   1        dir_in qualifier, 1-cycle pulse
//  good_collision in   1        head-on-apple, level (may stay high for many cycles)
//  bad_collision  in   1        head-on-border/body, level
//  apple_ack      in   1        new apple position loaded
//  shift_en       out  1        1-cycle pulse: shift body, move head by dir_out
//  dir_out        out  5        committed head direction, one-hot
//  clear_body     out  1        level: reset body segments to off-screen
//  apple_req      out  1        request new apple position; held until apple_ack
//  size           out  SIZE_W   current snake length
//  score          out  SCORE_W  apples eaten, saturating
//  game_over      out  1        high in OVER
//  state          out  3        current FSM state, for debug
// BEHAVIOUR
//  Reset values:
//   state=IDLE, shift_en=0, dir_out=10000, clear_body=1, apple_req=0, size=INIT_SIZE,
//   score=0, game_over=0, pend_dir=10000, good_q=0.
//  Priority each cycle: rst > start==0 (-> IDLE) > bad_collision > good edge > tick.
//  IDLE:
//   clear_body=1; size=INIT_SIZE; score=0; dir_out=pend_dir=10000.
//   start==1 -> PLAY next cycle.
//  PLAY:
//   tick -> shift_en=1 on the following cycle (latency 1).
//   Rising edge of good_collision (good & ~good_q) -> GROW.
//   bad_collision -> OVER. If bad and good occur in the same cycle, OVER wins.
//  GROW (1 cycle):
//   size<=size+1, saturating at MAX_SIZE; score<=score+1, saturating at all-ones.
//   Then -> RESPAWN with apple_req=1.
//  RESPAWN:
//   apple_req held at 1 until a cycle with apple_ack=1; apple_req drops the next cycle.
//   -> PLAY. Ticks still produce shift_en. bad_collision -> OVER, and apple_req drops.
//  OVER:
//   game_over=1; shift_en never asserts; ticks and dir_valid are ignored.
//   Exit only via start==0 -> IDLE.
//  Direction filter:
//   On dir_valid, dir_in is latched into pend_dir only if it is exactly one-hot and is
//   not the opposite of dir_out (up/down, left/right). Otherwise it is dropped.
//   On tick, dir_out<=pend_dir in the same edge that schedules shift_en.
//   A dir_valid in the tick cycle affects only the next tick.
//   Several dir_valid pulses between ticks: last legal one wins.
//  good_q: register of good_collision, updated every cycle. It is cleared in IDLE.
//  start dropping mid-RESPAWN: apple_req=0 next cycle, handshake abandoned, and a late
//   apple_ack is ignored.
// STRUCTURE
//  Shared include snake_defs.vh:
//   DIR_UP/LEFT/DOWN/RIGHT codes, state encodings
//   (IDLE=0, PLAY=1, GROW=2, RESPAWN=3, OVER=4), default MAX_SIZE.
//  Sub-module snake_dir_filter:
//   Holds pend_dir/dir_out and contains the one-hot and reversal checks.
//   Inputs: clk, rst, clear, dir_in, dir_valid, tick_en.
//  Top: FSM, size/score counters, collision edge detect, shift_en register.
// TESTING
//  1. rst, then start=1, 3 ticks spaced 10 cycles -> 3 shift_en pulses, each 1 cycle after
//     its tick; dir_out=10000.
//  2. In PLAY, dir_valid with 00100 (reverse of right) then 00010, then tick -> dir_out=00010.
//     Invalid 00110 is ignored.
//  3. good_collision high 20 cycles -> exactly one GROW, size 1->2, score 0->1, apple_req=1;
//     apple_ack after 5 cycles -> apple_req=0 next cycle, state=PLAY.
//  4. Force size=MAX_SIZE=16, eat apple -> size stays 16, score increments.
//  5. good and bad asserted in the same cycle -> OVER, game_over=1, no apple_req.
//     Ticks produce no shift_en.
//  6. start=0 during RESPAWN with apple_req=1 -> IDLE next cycle, apple_req=0, clear_body=1,
//     size=1, score=0.

Source files
------------

// File: rtl/snake_game_ctrl_pkg.sv
// Shared direction codes, state encoding and helpers for the snake game-flow controller.
package snake_game_ctrl_pkg;

  localparam logic [4:0] DIR_UP    = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_DOWN  = 5'b01000;
  localparam logic [4:0] DIR_RIGHT = 5'b10000;

  localparam int DEF_MAX_SIZE = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_GROW    = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  function automatic logic [4:0] dir_opposite(input logic [4:0] d);
    logic [4:0] o;
    o = 5'b00000;
    case (d)
      DIR_UP:    o = DIR_DOWN;
      DIR_DOWN:  o = DIR_UP;
      DIR_LEFT:  o = DIR_RIGHT;
      DIR_RIGHT: o = DIR_LEFT;
      default:   o = 5'b00000;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_dir_filter.sv
// Direction filter: latches legal one-hot requests into pend_dir and commits them on tick.
module snake_dir_filter
  import snake_game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [4:0] dir_in,
  input  logic       dir_valid,
  input  logic       tick_en,
  output logic [4:0] dir_out
);

  logic [4:0] pend_q, pend_d;
  logic [4:0] dir_out_q, dir_out_d;
  logic       legal;

  // reversal is judged against the committed heading, not the pending one
  assign legal = $onehot(dir_in) && (dir_in != dir_opposite(dir_out_q));

  always_comb begin
    pend_d    = pend_q;
    dir_out_d = dir_out_q;
    if (clear) begin
      pend_d    = DIR_RIGHT;
      dir_out_d = DIR_RIGHT;
    end else begin
      if (tick_en)            dir_out_d = pend_q;
      if (dir_valid && legal) pend_d    = dir_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= DIR_RIGHT;
      dir_out_q <= DIR_RIGHT;
    end else begin
      pend_q    <= pend_d;
      dir_out_q <= dir_out_d;
    end
  end

  assign dir_out = dir_out_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game-flow controller: state sequencing, shift pulse, size/score and apple handshake.
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int MAX_SIZE  = DEF_MAX_SIZE,
  parameter int INIT_SIZE = 1,
  parameter int SIZE_W    = 7,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [4:0]         dir_in,
  input  logic               dir_valid,
  input  logic               good_collision,
  input  logic               bad_collision,
  input  logic               apple_ack,
  output logic               shift_en,
  output logic [4:0]         dir_out,
  output logic               clear_body,
  output logic               apple_req,
  output logic [SIZE_W-1:0]  size,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic [2:0]         state
);

  state_e               state_q, state_d;
  logic [SIZE_W-1:0]    size_q, size_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 good_q, good_d;
  logic                 shift_en_q, shift_en_d;
  logic                 clear;
  logic                 moving;
  logic                 tick_en;
  logic                 good_edge;

  // start low behaves like IDLE immediately so counters are already clean on the IDLE cycle
  assign clear     = !start || (state_q == ST_IDLE);
  assign moving    = (state_q == ST_PLAY) || (state_q == ST_GROW) || (state_q == ST_RESPAWN);
  assign tick_en   = start && moving && tick && !bad_collision;
  assign good_edge = good_collision && !good_q;

  always_comb begin
    state_d = state_q;
    if (!start) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_PLAY;
        ST_PLAY:    if (bad_collision)  state_d = ST_OVER;
                    else if (good_edge) state_d = ST_GROW;
        ST_GROW:    state_d = bad_collision ? ST_OVER : ST_RESPAWN;
        ST_RESPAWN: if (bad_collision)  state_d = ST_OVER;
                    else if (apple_ack) state_d = ST_PLAY;
        ST_OVER:    state_d = ST_OVER;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    size_d     = size_q;
    score_d    = score_q;
    good_d     = clear ? 1'b0 : good_collision;
    shift_en_d = tick_en;
    if (clear) begin
      size_d  = SIZE_W'(INIT_SIZE);
      score_d = '0;
    end else if (state_q == ST_GROW) begin
      if (size_q != SIZE_W'(MAX_SIZE)) size_d  = size_q + 1'b1;
      if (!(&score_q))                 score_d = score_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      size_q     <= SIZE_W'(INIT_SIZE);
      score_q    <= '0;
      good_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      score_q    <= score_d;
      good_q     <= good_d;
      shift_en_q <= shift_en_d;
    end
  end

  snake_dir_filter u_dir_filter (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .dir_in    (dir_in),
    .dir_valid (dir_valid && (state_q != ST_OVER)),
    .tick_en   (tick_en),
    .dir_out   (dir_out)
  );

  assign shift_en   = shift_en_q;
  assign clear_body = (state_q == ST_IDLE);
  assign apple_req  = (state_q == ST_RESPAWN);
  assign game_over  = (state_q == ST_OVER);
  assign size       = size_q;
  assign score      = score_q;
  assign state      = state_q;

endmodule
